rps_key_ctrl: RTL and testbench
===============================

# rps_key_ctrl

Player-input front end for the rock-paper-scissors game: debounces the raw board buttons, locks each player's choice, and drives the `key`/`start` interface consumed by the `score` block. It is the producer side of that interface. `key` carries both players' encoded choices. `start` is a single-cycle pulse issued only when both choices are locked and the start button is pressed. It sits between the board button pins and `score`.

## Interface
- `DB_CYCLES`, default 20: consecutive cycles a raw input must differ from its debounced level before the level changes. Board builds override it with 1_000_000.
- `clk`  in  1  system clock; all state on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `btn_a`  in  3  player A raw buttons, active-high: [0] rock, [1] scissors, [2] paper.
- `btn_b`  in  3  player B raw buttons, same mapping.
- `btn_start`  in  1  raw start button, active-high.
- `key`  out  4  {a_code[1:0], b_code[1:0]}; code 2'b00 none, 2'b01 rock, 2'b10 scissors, 2'b11 paper.
- `start`  out  1  one-cycle round-start pulse to `score`.
- `lock_a`, `lock_b`  out  1 each  player choice locked (LED drive).

## Operation
- Debounce: 7 independent channels (6 choice buttons plus start).
  - Each channel has a counter of width clog2(DB_CYCLES+1).
  - The counter increments while raw ≠ level and clears when raw = level.
  - When the counter reaches DB_CYCLES, the level toggles and the counter clears.
  - Press event = level & ~level_prev (one cycle).
- Choice lock: a press event on an unlocked player loads that player's code and sets its lock.
  - Events on a locked player are ignored.
  - Same-cycle events on one player: priority rock > scissors > paper.
- FSM states: IDLE, COLLECT, READY, FIRE, DONE.
  - IDLE: no locks. Any lock → COLLECT. Both players locking in the same cycle → READY.
  - COLLECT: exactly one lock. The other player locks → READY.
  - READY: both locked. Start event → FIRE.
  - FIRE: `start`=1 for this one cycle, `key` stable → DONE.
  - DONE: `key` still stable, `start`=0 → IDLE, clearing both locks and codes.
- Start events outside READY are dropped and never queued.
- Simultaneous events:
  - Start event in the same cycle as the lock that completes the pair: start is dropped, state → READY.
  - Choice events in READY, FIRE or DONE are ignored.
- `key` shows the locked codes only; an unlocked player's field is 2'b00.

## Timing
- Reset values: `key`=4'h0, `start`=0, `lock_a`=`lock_b`=0, state IDLE, all counters 0, all debounced levels 0.
- Reset mid-round aborts the round immediately; no `start` pulse follows.
- A button held through reset release is treated as a fresh press, DB_CYCLES+1 cycles later.
- Latency: a raw rise is sampled constant for DB_CYCLES edges, then the level rises. The lock or `start` follows on the next edge, i.e. DB_CYCLES+1 edges after the first sampled high.
- Glitches shorter than DB_CYCLES cycles produce no event.
- `key` is stable from the READY entry edge through the end of DONE, at least 2 cycles around the `start` pulse.
- Releases generate no events. A new press requires release, debounced low, then press again.

## Structure
- Shared package `rps_pkg`: choice codes (CH_NONE, CH_ROCK, CH_SCISSORS, CH_PAPER), FSM state enum, DB_CYCLES default constant. `score` uses the same choice codes.
- Sub-module `btn_debounce` (parameter DB_CYCLES; ports `clk`, `rst`, `raw`, `level`, `press`), instantiated 7 times.
- Top level holds the priority encoders, lock registers and FSM.

## Test plan
- DB_CYCLES=4. A rock held 10 cycles, then B paper held 10 cycles → `lock_a` 5 edges after A's press, `key`=4'b0100; then `key`=4'b0111, state READY, `start`=0.
- In READY, `btn_start` held 6 cycles → exactly one `start` pulse 5 edges after the press, `key`=4'b0111 during it and the next cycle, then `key`=0 and both locks clear.
- 3-cycle glitch on `btn_a[1]` and a 3-cycle glitch on `btn_start` → no lock, no `start`.
- `btn_start` pressed in IDLE and in COLLECT → no `start`; after B locks, a new start press yields one pulse.
- A presses rock and paper in the same cycle → a_code=2'b01. A later A scissors press is ignored and a_code stays 2'b01.
- `rst` asserted in READY while `btn_a[0]` is held → all outputs 0 immediately; after release, `lock_a` asserts 5 edges later with a_code=2'b01.

Source files
------------

// File: rtl/rps_pkg.sv
// -----------------------------------------------------------------------------
// rps_pkg
// Shared definitions for the rock-paper-scissors player front end and the
// score block: choice codes, controller state encoding, default debounce
// length and the per-player choice priority encoder.
// -----------------------------------------------------------------------------
package rps_pkg;

  // Board builds override this with 1_000_000 (tens of ms at board clock).
  localparam int DB_CYCLES_DEF = 20;

  typedef enum logic [1:0] {
    CH_NONE     = 2'b00,
    CH_ROCK     = 2'b01,
    CH_SCISSORS = 2'b10,
    CH_PAPER    = 2'b11
  } choice_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_READY   = 3'd2,
    ST_FIRE    = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Press events of one player -> choice code. Bit order of ev is
  // [0] rock, [1] scissors, [2] paper; when several land in the same cycle
  // rock wins over scissors, scissors over paper.
  function automatic choice_t encode_choice(input logic [2:0] ev);
    choice_t c;
    c = CH_NONE;
    if (ev[0])      c = CH_ROCK;
    else if (ev[1]) c = CH_SCISSORS;
    else if (ev[2]) c = CH_PAPER;
    return c;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// One debounce channel. The debounced level changes only after the raw input
// has been sampled different from it for DB_CYCLES consecutive edges; any
// sample equal to the level restarts the count. press is a one-cycle pulse on
// each rising edge of the debounced level (releases produce nothing).
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-high reset (level 0, count 0)
//   raw    in   raw button pin, active-high
//   level  out  debounced level
//   press  out  one-cycle pulse when level goes 0 -> 1
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int DB_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  // The count toggles the level on the edge where it would reach DB_CYCLES,
  // so the register itself only ever needs to hold up to DB_CYCLES-1.
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          prev_q;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (raw != level_q) begin
      if (cnt_q == CNT_LAST) level_d = ~level_q;
      else                   cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      prev_q  <= level_q;
    end
  end

  assign level = level_q;
  assign press = level_q & ~prev_q;

endmodule

// File: rtl/rps_key_ctrl.sv
// -----------------------------------------------------------------------------
// rps_key_ctrl
// Player-input front end for rock-paper-scissors. Debounces the six choice
// buttons and the start button, locks the first choice each player makes,
// and drives the key/start interface of the score block.
//
// Handshake with score: key is valid and held stable from the cycle the
// controller enters READY until the end of DONE; start is a single-cycle
// pulse in FIRE and score samples key while start is high. There is no
// back-pressure: score must accept the pulse in that cycle.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset, aborts any round
//   btn_a[2:0] in   player A raw buttons: [0] rock [1] scissors [2] paper
//   btn_b[2:0] in   player B raw buttons, same mapping
//   btn_start  in   raw start button
//   key[3:0]   out  {a_code, b_code}; unlocked player's field is 2'b00
//   start      out  one-cycle round start pulse
//   lock_a/b   out  player choice locked (LED drive)
//   dbg_state  out  controller state (rps_pkg::state_t encoding)
//   dbg_level  out  debounced levels {start, b[2:0], a[2:0]}
// -----------------------------------------------------------------------------
module rps_key_ctrl
  import rps_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] btn_a,
  input  logic [2:0] btn_b,
  input  logic       btn_start,
  output logic [3:0] key,
  output logic       start,
  output logic       lock_a,
  output logic       lock_b,
  output logic [2:0] dbg_state,
  output logic [6:0] dbg_level
);

  logic [2:0] a_ev, b_ev;
  logic       st_ev;

  for (genvar i = 0; i < 3; i++) begin : g_db
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_a (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_a[i]),
      .level (dbg_level[i]),
      .press (a_ev[i])
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_b (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_b[i]),
      .level (dbg_level[3+i]),
      .press (b_ev[i])
    );
  end

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_start),
    .level (dbg_level[6]),
    .press (st_ev)
  );

  state_t  state_q, state_d;
  choice_t a_code_q, a_code_d;
  choice_t b_code_q, b_code_d;
  logic    a_lock_q, a_lock_d;
  logic    b_lock_q, b_lock_d;

  // A player can only take a choice while still unlocked.
  logic a_take, b_take;
  assign a_take = ~a_lock_q & (|a_ev);
  assign b_take = ~b_lock_q & (|b_ev);

  always_comb begin
    state_d  = state_q;
    a_code_d = a_code_q;
    b_code_d = b_code_q;
    a_lock_d = a_lock_q;
    b_lock_d = b_lock_q;
    case (state_q)
      // IDLE and COLLECT share the lock logic; a start press here is
      // dropped, including one that lands with the pair-completing lock.
      ST_IDLE, ST_COLLECT: begin
        if (a_take) begin
          a_lock_d = 1'b1;
          a_code_d = encode_choice(a_ev);
        end
        if (b_take) begin
          b_lock_d = 1'b1;
          b_code_d = encode_choice(b_ev);
        end
        if (a_lock_d && b_lock_d)      state_d = ST_READY;
        else if (a_lock_d || b_lock_d) state_d = ST_COLLECT;
      end
      ST_READY: begin
        if (st_ev) state_d = ST_FIRE;
      end
      ST_FIRE: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        a_lock_d = 1'b0;
        b_lock_d = 1'b0;
        a_code_d = CH_NONE;
        b_code_d = CH_NONE;
      end
      default: begin
        state_d  = ST_IDLE;
        a_lock_d = 1'b0;
        b_lock_d = 1'b0;
        a_code_d = CH_NONE;
        b_code_d = CH_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_code_q <= CH_NONE;
      b_code_q <= CH_NONE;
      a_lock_q <= 1'b0;
      b_lock_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_code_q <= a_code_d;
      b_code_q <= b_code_d;
      a_lock_q <= a_lock_d;
      b_lock_q <= b_lock_d;
    end
  end

  assign key       = {(a_lock_q ? a_code_q : CH_NONE), (b_lock_q ? b_code_q : CH_NONE)};
  assign start     = (state_q == ST_FIRE);
  assign lock_a    = a_lock_q;
  assign lock_b    = b_lock_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rps_key_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rps_key_ctrl
// Scoreboard bench. A reference model evaluated on every rising edge pushes
// each change of the output vector {start, lock_a, lock_b, key}, stamped with
// its cycle number, into exp_q. A monitor on the falling edge pops an entry
// whenever the DUT's output vector changes and compares stamp and value.
// Directed sequences are followed by a randomized button phase.
// -----------------------------------------------------------------------------
module tb_rps_key_ctrl;
  import rps_pkg::*;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] btn_a = 3'b000;
  logic [2:0] btn_b = 3'b000;
  logic       btn_start = 1'b0;
  logic [3:0] key;
  logic       start, lock_a, lock_b;
  logic [2:0] dbg_state;
  logic [6:0] dbg_level;

  rps_key_ctrl #(.DB_CYCLES(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_a     (btn_a),
    .btn_b     (btn_b),
    .btn_start (btn_start),
    .key       (key),
    .start     (start),
    .lock_a    (lock_a),
    .lock_b    (lock_b),
    .dbg_state (dbg_state),
    .dbg_level (dbg_level)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [22:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Channel index: 0..2 player A, 3..5 player B, 6 start.
  logic [31:0] m_hist[7];
  logic        m_lvl[7];
  logic        m_prev[7];
  logic [1:0]  m_a, m_b;
  int          m_phase;      // 0 choosing/waiting, 1 start pulse cycle, 2 hold cycle
  logic [6:0]  m_vec_prev;
  logic [6:0]  m_raw, m_ev;
  logic [6:0]  m_vec;

  function automatic logic [1:0] pick(input logic [2:0] ev);
    if (ev[0]) return 2'b01;
    if (ev[1]) return 2'b10;
    if (ev[2]) return 2'b11;
    return 2'b00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 7; i++) begin
      m_hist[i] = '0;
      m_lvl[i]  = 1'b0;
      m_prev[i] = 1'b0;
    end
    m_a        = 2'b00;
    m_b        = 2'b00;
    m_phase    = 0;
    m_vec_prev = '0;
  endtask

  initial begin : model
    model_reset();
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        model_reset();
        exp_q.delete();
      end else begin
        m_raw = {btn_start, btn_b, btn_a};
        for (int i = 0; i < 7; i++) m_ev[i] = m_lvl[i] & ~m_prev[i];
        // Round progression.
        if (m_phase == 2) begin
          m_phase = 0;
          m_a = 2'b00;
          m_b = 2'b00;
        end else if (m_phase == 1) begin
          m_phase = 2;
        end else if (m_a != 2'b00 && m_b != 2'b00) begin
          if (m_ev[6]) m_phase = 1;
        end else begin
          if (m_a == 2'b00) m_a = pick(m_ev[2:0]);
          if (m_b == 2'b00) m_b = pick(m_ev[5:3]);
        end
        // Debounce: level flips once the last DB samples all oppose it.
        for (int i = 0; i < 7; i++) begin
          m_prev[i] = m_lvl[i];
          m_hist[i] = {m_hist[i][30:0], m_raw[i]};
          if (m_lvl[i] ? (m_hist[i][DB-1:0] == '0) : (m_hist[i][DB-1:0] == {DB{1'b1}}))
            m_lvl[i] = ~m_lvl[i];
        end
        m_vec = {(m_phase == 1), (m_a != 2'b00), (m_b != 2'b00), m_a, m_b};
        if (m_vec != m_vec_prev) begin
          exp_q.push_back({cyc[15:0], m_vec});
          m_vec_prev = m_vec;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  logic [6:0]  d_prev = '0;
  logic [6:0]  d_vec;
  logic [22:0] d_exp;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst) begin
        d_prev = '0;
      end else begin
        d_vec = {start, lock_a, lock_b, key};
        if (d_vec != d_prev) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL out_change: got vec 0x%0h at cycle %0d, expected no change", d_vec, cyc);
          end else begin
            d_exp = exp_q.pop_front();
            check("out_change", {9'd0, cyc[15:0], d_vec}, {9'd0, d_exp});
          end
          d_prev = d_vec;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin : stim
    // Reset.
    step(3);
    check("rst_key", key, 4'h0);
    check("rst_start", start, 1'b0);
    check("rst_locks", {lock_a, lock_b}, 2'b00);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_level", dbg_level, 7'h0);
    rst = 1'b0;
    step(2);

    // A rock, then B paper.
    btn_a = 3'b001;
    step(4);
    check("a_lock_early", lock_a, 1'b0);
    step(1);
    check("a_lock_latency", lock_a, 1'b1);
    check("key_a_rock", key, 4'b0100);
    step(5);
    btn_a = 3'b000;
    btn_b = 3'b100;
    step(10);
    btn_b = 3'b000;
    step(2);
    check("key_pair", key, 4'b0111);
    check("state_ready", dbg_state, ST_READY);
    check("no_start_ready", start, 1'b0);

    // Start held 6 cycles -> one pulse.
    btn_start = 1'b1;
    step(4);
    check("start_early", start, 1'b0);
    step(1);
    check("start_pulse", start, 1'b1);
    check("key_at_start", key, 4'b0111);
    step(1);
    btn_start = 1'b0;
    check("start_one_cycle", start, 1'b0);
    check("key_after_start", key, 4'b0111);
    step(1);
    check("key_cleared", key, 4'h0);
    check("locks_cleared", {lock_a, lock_b}, 2'b00);
    step(8);

    // Short glitches.
    btn_a = 3'b010;
    step(3);
    btn_a = 3'b000;
    btn_start = 1'b1;
    step(3);
    btn_start = 1'b0;
    step(10);
    check("glitch_no_lock", lock_a, 1'b0);
    check("glitch_state", dbg_state, ST_IDLE);

    // Start in IDLE and COLLECT is dropped; start after pair fires.
    btn_start = 1'b1; step(8); btn_start = 1'b0; step(8);
    btn_a = 3'b001;   step(8); btn_a = 3'b000;     step(8);
    btn_start = 1'b1; step(8); btn_start = 1'b0; step(8);
    check("collect_state", dbg_state, ST_COLLECT);
    btn_b = 3'b010;   step(8); btn_b = 3'b000;     step(8);
    check("key_rock_sc", key, 4'b0110);
    btn_start = 1'b1; step(8); btn_start = 1'b0; step(10);
    check("round2_done", dbg_state, ST_IDLE);

    // A rock + paper together -> rock; later scissors ignored.
    btn_a = 3'b101; step(8); btn_a = 3'b000; step(8);
    btn_a = 3'b010; step(8); btn_a = 3'b000; step(8);
    check("a_prio_rock", key[3:2], 2'b01);

    // B paper -> READY, then reset while A rock is held.
    btn_b = 3'b100; step(8); btn_b = 3'b000; step(8);
    btn_a = 3'b001;
    step(3);
    rst = 1'b1;
    #1;
    check("midround_rst_key", key, 4'h0);
    check("midround_rst_out", {start, lock_a, lock_b}, 3'b000);
    step(2);
    rst = 1'b0;
    step(4);
    check("held_after_rst_early", lock_a, 1'b0);
    step(1);
    check("held_after_rst_lock", lock_a, 1'b1);
    check("held_after_rst_code", key, 4'b0100);
    btn_a = 3'b000;
    step(8);

    // Randomized button activity.
    for (int n = 0; n < 3000; n++) begin
      int k;
      if ($urandom_range(0, 7) == 0) begin
        k = $urandom_range(0, 2);
        btn_a[k] = ~btn_a[k];
      end
      if ($urandom_range(0, 7) == 0) begin
        k = $urandom_range(0, 2);
        btn_b[k] = ~btn_b[k];
      end
      if ($urandom_range(0, 9) == 0) btn_start = ~btn_start;
      if ($urandom_range(0, 999) == 0) begin
        rst = 1'b1;
        step(2);
        rst = 1'b0;
      end
      step(1);
    end
    btn_a = 3'b000;
    btn_b = 3'b000;
    btn_start = 1'b0;
    step(12);

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
